// File: rtl/unsigned_clz_divider_if.sv
// Request/response bundle between the div_unit requester (master) and the divider (slave).
// Operands and CLZ counts are meaningful only in the cycle start is accepted.
interface unsigned_clz_divider_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int CLZW = $clog2(DATA_WIDTH);

    logic                  start;
    logic [DATA_WIDTH-1:0] dividend;
    logic [CLZW-1:0]       dividend_CLZ;
    logic [DATA_WIDTH-1:0] divisor;
    logic [CLZW-1:0]       divisor_CLZ;
    logic                  divisor_is_zero;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;

    modport master (
        output start, dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/unsigned_clz_divider.sv
// Radix-2 restoring unsigned divider; UNSIGNED_DIV_EARLY_TERM_EN enables CLZ alignment/early exit.
// Latency: 1 edge for fast paths, N+1 edges otherwise (N = CLZ gap + 1, or DATA_WIDTH without the macro).
// Backpressure: start is accepted only while busy is low; requests during busy/done are dropped.
module unsigned_clz_divider #(
    parameter int DATA_WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst,
    unsigned_clz_divider_if.slave  div_if
);
    localparam int CLZW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic [CLZW-1:0]       cnt_q, cnt_d;

    logic [DATA_WIDTH:0]   part;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] rem_next, quo_next, dvs_next;

`ifdef UNSIGNED_DIV_EARLY_TERM_EN
    logic [CLZW-1:0] shift;
    assign shift = div_if.divisor_CLZ - div_if.dividend_CLZ;

    // Divisor is pre-aligned to the dividend MSB and walks right one bit per step.
    always_comb begin
        part     = {1'b0, rem_q};
        diff     = part - {1'b0, dvs_q};
        rem_next = diff[DATA_WIDTH] ? rem_q : diff[DATA_WIDTH-1:0];
        quo_next = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        dvs_next = dvs_q >> 1;
    end
`else
    // Classic form: dividend bits shift out of quo_q into the partial remainder.
    always_comb begin
        part     = {rem_q, quo_q[DATA_WIDTH-1]};
        diff     = part - {1'b0, dvs_q};
        rem_next = diff[DATA_WIDTH] ? part[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
        quo_next = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        dvs_next = dvs_q;
    end
`endif

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    if (div_if.divisor_is_zero) begin
                        quotient_d  = '1;
                        remainder_d = div_if.dividend;
                        state_d     = FIN;
`ifdef UNSIGNED_DIV_EARLY_TERM_EN
                    end else if (div_if.divisor_CLZ < div_if.dividend_CLZ) begin
                        quotient_d  = '0;
                        remainder_d = div_if.dividend;
                        state_d     = FIN;
                    end else begin
                        rem_d   = div_if.dividend;
                        dvs_d   = div_if.divisor << shift;
                        quo_d   = '0;
                        cnt_d   = shift;
                        state_d = RUN;
                    end
`else
                    end else begin
                        rem_d   = '0;
                        dvs_d   = div_if.divisor;
                        quo_d   = div_if.dividend;
                        cnt_d   = CLZW'(DATA_WIDTH - 1);
                        state_d = RUN;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = rem_next;
                quo_d = quo_next;
                dvs_d = dvs_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quotient_d  = quo_next;
                    remainder_d = rem_next;
                    state_d     = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign div_if.busy      = (state_q != IDLE);
    assign div_if.done      = (state_q == FIN);
    assign div_if.quotient  = quotient_q;
    assign div_if.remainder = remainder_q;
endmodule
